// File: rtl/data_memory_arbiter.sv
// Data memory arbiter.
// Shares the single-port data memory between the CPU load/store stage
// (requester 0, high priority) and the debug/program loader (requester 1).
// A starvation counter forces a loader win after STARVE_LIMIT refused cycles.
// Read responses come back one cycle after issue. They are routed to the
// requester that owns the outstanding read, together with its misaligned flag.
module data_memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  // CPU load/store requester
  input  logic        i_CpuValid,
  input  logic        i_CpuWrite,
  input  logic [2:0]  i_CpuMode,
  input  logic [31:0] i_CpuAddress,
  input  logic [31:0] i_CpuWriteData,
  output logic        o_CpuReady,
  output logic        o_CpuRespValid,
  output logic [31:0] o_CpuReadData,
  output logic        o_CpuError,
  // Debug / program loader requester
  input  logic        i_DbgValid,
  input  logic        i_DbgWrite,
  input  logic [2:0]  i_DbgMode,
  input  logic [31:0] i_DbgAddress,
  input  logic [31:0] i_DbgWriteData,
  output logic        o_DbgReady,
  output logic        o_DbgRespValid,
  output logic [31:0] o_DbgReadData,
  output logic        o_DbgError,
  // Memory side
  output logic        o_MemWriteEnable,
  output logic        o_MemReadEnable,
  output logic [2:0]  o_MemMode,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataOut,
  input  logic [31:0] i_MemDataIn,
  input  logic        i_MemMisaligned
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic       cpu_grant;
  logic       dbg_grant;
  logic [3:0] starve_count_q, starve_count_d;
  logic       pend_cpu_q, pend_cpu_d;
  logic       pend_dbg_q, pend_dbg_d;
  logic       pend_err_q, pend_err_d;

  // Pick this cycle's winner: CPU first, loader when starved or alone, nobody in reset
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!i_Reset) begin
      if (i_CpuValid && i_DbgValid) begin
        if (starve_count_q == STARVE_MAX) begin
          dbg_grant = 1'b1;
        end else begin
          cpu_grant = 1'b1;
        end
      end else if (i_CpuValid) begin
        cpu_grant = 1'b1;
      end else if (i_DbgValid) begin
        dbg_grant = 1'b1;
      end
    end
  end

  // Steer the winner's request fields onto the memory port, zero when idle
  always_comb begin
    o_MemWriteEnable = 1'b0;
    o_MemReadEnable  = 1'b0;
    o_MemMode        = 3'd0;
    o_MemAddress     = 32'd0;
    o_MemDataOut     = 32'd0;
    if (cpu_grant) begin
      o_MemWriteEnable = i_CpuWrite;
      o_MemReadEnable  = !i_CpuWrite;
      o_MemMode        = i_CpuMode;
      o_MemAddress     = i_CpuAddress;
      o_MemDataOut     = i_CpuWriteData;
    end else if (dbg_grant) begin
      o_MemWriteEnable = i_DbgWrite;
      o_MemReadEnable  = !i_DbgWrite;
      o_MemMode        = i_DbgMode;
      o_MemAddress     = i_DbgAddress;
      o_MemDataOut     = i_DbgWriteData;
    end
  end

  // Next starvation count: clear on a loader win, count refused loader cycles up to the limit
  always_comb begin
    starve_count_d = starve_count_q;
    if (dbg_grant) begin
      starve_count_d = 4'd0;
    end else if (i_DbgValid && (starve_count_q < STARVE_MAX)) begin
      starve_count_d = starve_count_q + 4'd1;
    end
  end

  // Tag the read issued this cycle so its data returns to the right owner next cycle
  always_comb begin
    pend_cpu_d = cpu_grant && !i_CpuWrite;
    pend_dbg_d = dbg_grant && !i_DbgWrite;
    pend_err_d = (pend_cpu_d || pend_dbg_d) && i_MemMisaligned;
  end

  // State registers with synchronous reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      starve_count_q <= 4'd0;
      pend_cpu_q     <= 1'b0;
      pend_dbg_q     <= 1'b0;
      pend_err_q     <= 1'b0;
    end else begin
      starve_count_q <= starve_count_d;
      pend_cpu_q     <= pend_cpu_d;
      pend_dbg_q     <= pend_dbg_d;
      pend_err_q     <= pend_err_d;
    end
  end

  // Handshake and response outputs; every output is held quiet while reset is asserted
  always_comb begin
    o_CpuReady     = cpu_grant;
    o_DbgReady     = dbg_grant;
    o_CpuRespValid = pend_cpu_q && !i_Reset;
    o_DbgRespValid = pend_dbg_q && !i_Reset;
    o_CpuReadData  = o_CpuRespValid ? i_MemDataIn : 32'd0;
    o_DbgReadData  = o_DbgRespValid ? i_MemDataIn : 32'd0;
    o_CpuError     = o_CpuRespValid && pend_err_q;
    o_DbgError     = o_DbgRespValid && pend_err_q;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter (STARVE_LIMIT = 4).
// Directed per-cycle vectors carry hand-chosen grant expectations. Each expected
// read response is queued and later checked by an independent monitor.
module tb_data_memory_arbiter;

  localparam logic [2:0] LOAD_WORD  = 3'b010;
  localparam logic [2:0] STORE_BYTE = 3'b101;
  localparam logic [2:0] STORE_WORD = 3'b111;

  typedef struct {
    logic        valid;
    logic        write;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          cyc;
    bit          is_cpu;
    logic [31:0] data;
    logic        err;
    bit          check_data;
  } resp_t;

  logic        i_Clock;
  logic        i_Reset;
  logic        i_CpuValid, i_CpuWrite;
  logic [2:0]  i_CpuMode;
  logic [31:0] i_CpuAddress, i_CpuWriteData;
  logic        o_CpuReady, o_CpuRespValid, o_CpuError;
  logic [31:0] o_CpuReadData;
  logic        i_DbgValid, i_DbgWrite;
  logic [2:0]  i_DbgMode;
  logic [31:0] i_DbgAddress, i_DbgWriteData;
  logic        o_DbgReady, o_DbgRespValid, o_DbgError;
  logic [31:0] o_DbgReadData;
  logic        o_MemWriteEnable, o_MemReadEnable;
  logic [2:0]  o_MemMode;
  logic [31:0] o_MemAddress, o_MemDataOut;
  logic [31:0] i_MemDataIn;
  logic        i_MemMisaligned;

  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  bit    mon_en      = 1'b0;
  resp_t sb[$];

  data_memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_CpuValid(i_CpuValid), .i_CpuWrite(i_CpuWrite), .i_CpuMode(i_CpuMode),
    .i_CpuAddress(i_CpuAddress), .i_CpuWriteData(i_CpuWriteData),
    .o_CpuReady(o_CpuReady), .o_CpuRespValid(o_CpuRespValid),
    .o_CpuReadData(o_CpuReadData), .o_CpuError(o_CpuError),
    .i_DbgValid(i_DbgValid), .i_DbgWrite(i_DbgWrite), .i_DbgMode(i_DbgMode),
    .i_DbgAddress(i_DbgAddress), .i_DbgWriteData(i_DbgWriteData),
    .o_DbgReady(o_DbgReady), .o_DbgRespValid(o_DbgRespValid),
    .o_DbgReadData(o_DbgReadData), .o_DbgError(o_DbgError),
    .o_MemWriteEnable(o_MemWriteEnable), .o_MemReadEnable(o_MemReadEnable),
    .o_MemMode(o_MemMode), .o_MemAddress(o_MemAddress), .o_MemDataOut(o_MemDataOut),
    .i_MemDataIn(i_MemDataIn), .i_MemMisaligned(i_MemMisaligned)
  );

  // Free-running clock
  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // Cycle counter used to time-stamp expected responses
  always @(posedge i_Clock) cyc <= cyc + 1;

  // Memory contents seen by a read: one fixed word, otherwise a pattern of the address
  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h0000_0010) return 32'h1234_5678;
    return addr ^ 32'h5A5A_0000;
  endfunction

  // Registered memory read port; garbage when no read was issued
  always @(posedge i_Clock) begin
    i_MemDataIn <= o_MemReadEnable ? mem_model(o_MemAddress) : 32'hDEAD_BEEF;
  end

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic req_t idle_req();
    req_t r;
    r.valid = 1'b0; r.write = 1'b0; r.mode = 3'd0; r.addr = 32'd0; r.wdata = 32'd0;
    return r;
  endfunction

  function automatic req_t rd(input logic [31:0] addr);
    req_t r;
    r.valid = 1'b1; r.write = 1'b0; r.mode = LOAD_WORD; r.addr = addr; r.wdata = 32'd0;
    return r;
  endfunction

  function automatic req_t wr(input logic [2:0] mode, input logic [31:0] addr,
                              input logic [31:0] data);
    req_t r;
    r.valid = 1'b1; r.write = 1'b1; r.mode = mode; r.addr = addr; r.wdata = data;
    return r;
  endfunction

  // Drive one cycle of requests, check grant and memory port, queue any expected response
  task automatic apply_stimulus(input req_t cpu, input req_t dbg, input logic mis,
                                input logic rst, input logic exp_cpu, input logic exp_dbg);
    req_t  w;
    resp_t e;
    @(posedge i_Clock);
    #1;
    i_Reset         = rst;
    i_CpuValid      = cpu.valid; i_CpuWrite = cpu.write; i_CpuMode = cpu.mode;
    i_CpuAddress    = cpu.addr;  i_CpuWriteData = cpu.wdata;
    i_DbgValid      = dbg.valid; i_DbgWrite = dbg.write; i_DbgMode = dbg.mode;
    i_DbgAddress    = dbg.addr;  i_DbgWriteData = dbg.wdata;
    i_MemMisaligned = mis;
    @(negedge i_Clock);
    check_output("cpu_ready", 32'(o_CpuReady), 32'(exp_cpu));
    check_output("dbg_ready", 32'(o_DbgReady), 32'(exp_dbg));
    w = exp_cpu ? cpu : (exp_dbg ? dbg : idle_req());
    check_output("mem_we",   32'(o_MemWriteEnable), 32'(w.valid && w.write));
    check_output("mem_re",   32'(o_MemReadEnable),  32'(w.valid && !w.write));
    check_output("mem_mode", 32'(o_MemMode), 32'(w.mode));
    check_output("mem_addr", o_MemAddress, w.addr);
    check_output("mem_data", o_MemDataOut, w.wdata);
    if (w.valid && !w.write) begin
      e.cyc = cyc + 1; e.is_cpu = exp_cpu; e.data = mem_model(w.addr);
      e.err = mis; e.check_data = !mis;
      sb.push_back(e);
    end
  endtask

  // Response monitor: pops the queue when a response is due, else requires silence
  always @(negedge i_Clock) begin
    resp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check_output("cpu_resp_valid", 32'(o_CpuRespValid), 32'(e.is_cpu));
        check_output("dbg_resp_valid", 32'(o_DbgRespValid), 32'(!e.is_cpu));
        if (e.is_cpu) begin
          if (e.check_data) check_output("cpu_read_data", o_CpuReadData, e.data);
          check_output("cpu_error", 32'(o_CpuError), 32'(e.err));
          check_output("dbg_read_data_idle", o_DbgReadData, 32'd0);
        end else begin
          if (e.check_data) check_output("dbg_read_data", o_DbgReadData, e.data);
          check_output("dbg_error", 32'(o_DbgError), 32'(e.err));
          check_output("cpu_read_data_idle", o_CpuReadData, 32'd0);
        end
      end else begin
        check_output("no_resp_valid", {30'd0, o_CpuRespValid, o_DbgRespValid}, 32'd0);
        check_output("no_resp_error", {30'd0, o_CpuError, o_DbgError}, 32'd0);
      end
    end
  end

  // Directed scenario sequence
  initial begin
    logic [31:0] cpu_addr;
    logic        dbg_win;
    i_Reset = 1'b1;
    i_CpuValid = 1'b0; i_CpuWrite = 1'b0; i_CpuMode = 3'd0;
    i_CpuAddress = 32'd0; i_CpuWriteData = 32'd0;
    i_DbgValid = 1'b0; i_DbgWrite = 1'b0; i_DbgMode = 3'd0;
    i_DbgAddress = 32'd0; i_DbgWriteData = 32'd0;
    i_MemMisaligned = 1'b0;
    i_MemDataIn = 32'd0;

    // Reset: everything quiet
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b1, 1'b0, 1'b0);
    mon_en = 1'b1;
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b1, 1'b0, 1'b0);

    // CPU-only read of 0x10 returning 0x12345678
    apply_stimulus(rd(32'h10), idle_req(), 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Contention: loader write to 0x100 wins in cycles 4 and 9 of a CPU read stream
    cpu_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      dbg_win = (i == 4) || (i == 9);
      apply_stimulus(rd(cpu_addr), wr(STORE_WORD, 32'h100, 32'hCAFE_0000 + 32'(i)),
                     1'b0, 1'b0, !dbg_win, dbg_win);
      if (!dbg_win) cpu_addr = cpu_addr + 32'd4;
    end
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Withdrawn loader request keeps its count: refused twice, absent three cycles, wins on third retry
    for (int i = 0; i < 8; i++) begin
      dbg_win = (i == 7);
      apply_stimulus(dbg_win ? idle_req() : rd(32'h300 + 32'(4 * i)),
                     (i >= 2 && i <= 4) ? idle_req() : rd(32'h200),
                     1'b0, 1'b0, !dbg_win, dbg_win);
    end
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Alternating owners back to back
    apply_stimulus(rd(32'h40), idle_req(), 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(idle_req(), rd(32'h44), 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Misaligned CPU word load reports an error with its response
    apply_stimulus(rd(32'h2), idle_req(), 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Loader byte store to 0x3: passed through, never answered
    apply_stimulus(idle_req(), wr(STORE_BYTE, 32'h3, 32'h0000_00AB), 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Build up starvation, then reset with a CPU read pending acceptance
    apply_stimulus(wr(STORE_WORD, 32'h500, 32'h1), wr(STORE_WORD, 32'h600, 32'h2),
                   1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(wr(STORE_WORD, 32'h504, 32'h3), wr(STORE_WORD, 32'h600, 32'h2),
                   1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(rd(32'h80), wr(STORE_WORD, 32'h600, 32'h2), 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);
    // Counter restarted from zero: four CPU wins before the loader
    for (int i = 0; i < 5; i++) begin
      dbg_win = (i == 4);
      apply_stimulus(rd(32'h90 + 32'(4 * i)), wr(STORE_WORD, 32'h600, 32'h2),
                     1'b0, 1'b0, !dbg_win, dbg_win);
    end

    // Drain
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(idle_req(), idle_req(), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
